// File: rtl/centroid_sequencer.sv
// Frame centroid engine: accumulates object-pixel coordinates over one raster
// frame, then divides both sums by the pixel count with a bit-serial restoring divider.
module centroid_sequencer #(
    parameter int INPUT_WIDTH = 11,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SUM_WIDTH   = 27,
    parameter int COUNT_WIDTH = 19
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   frame_start,
    input  logic                   pixel_valid,
    input  logic                   object_pixel,
    output logic [INPUT_WIDTH-1:0] x_position,
    output logic [INPUT_WIDTH-1:0] y_position,
    output logic                   valid_position,
    output logic                   object_found,
    output logic                   busy
);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DIV_X, S_DIV_Y, S_DONE} state_t;

    localparam int BW = $clog2(SUM_WIDTH + 1);
    localparam logic [BW-1:0]          BIT_LAST = BW'(SUM_WIDTH - 1);
    localparam logic [INPUT_WIDTH-1:0] X_LAST   = INPUT_WIDTH'(H_ACTIVE - 1);
    localparam logic [INPUT_WIDTH-1:0] Y_LAST   = INPUT_WIDTH'(V_ACTIVE - 1);

    state_t r_state, w_state_next;

    logic [INPUT_WIDTH-1:0] r_x, r_y;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [SUM_WIDTH-1:0]   r_xsum, r_ysum;
    logic [SUM_WIDTH-1:0]   r_dvd, r_rem;
    logic [BW-1:0]          r_bit;
    logic [INPUT_WIDTH-1:0] r_qx;
    logic [INPUT_WIDTH-1:0] r_x_pos, r_y_pos;
    logic                   r_valid, r_found;

    logic                   w_start, w_accept, w_hit, w_last, w_x_wrap, w_bit_last;
    logic [INPUT_WIDTH-1:0] w_cur_x, w_cur_y;
    logic [COUNT_WIDTH-1:0] w_cnt_new;
    logic [SUM_WIDTH-1:0]   w_xsum_new, w_ysum_new;
    logic [SUM_WIDTH:0]     w_shift, w_den;
    logic                   w_ge;
    logic [SUM_WIDTH-1:0]   w_rem_next, w_quo_next;

    // A frame_start pixel always restarts the frame at (0,0) with empty accumulators.
    assign w_start  = frame_start & pixel_valid;
    assign w_accept = (r_state == S_ACCUM) ? pixel_valid
                    : (((r_state == S_IDLE) || (r_state == S_DONE)) && w_start);
    assign w_cur_x  = w_start ? '0 : r_x;
    assign w_cur_y  = w_start ? '0 : r_y;
    assign w_hit    = w_accept & object_pixel;
    assign w_x_wrap = (w_cur_x == X_LAST);
    assign w_last   = w_accept && w_x_wrap && (w_cur_y == Y_LAST);

    assign w_cnt_new  = (w_start ? '0 : r_count) + COUNT_WIDTH'(w_hit);
    assign w_xsum_new = (w_start ? '0 : r_xsum) + (w_hit ? SUM_WIDTH'(w_cur_x) : '0);
    assign w_ysum_new = (w_start ? '0 : r_ysum) + (w_hit ? SUM_WIDTH'(w_cur_y) : '0);

    // Restoring divider step; the quotient shifts into the dividend register from the LSB.
    assign w_shift    = {r_rem, r_dvd[SUM_WIDTH-1]};
    assign w_den      = (SUM_WIDTH + 1)'(r_count);
    assign w_ge       = (w_shift >= w_den);
    assign w_rem_next = w_ge ? SUM_WIDTH'(w_shift - w_den) : w_shift[SUM_WIDTH-1:0];
    assign w_quo_next = {r_dvd[SUM_WIDTH-2:0], w_ge};
    assign w_bit_last = (r_bit == BIT_LAST);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_ACCUM;
            S_ACCUM: if (w_last) w_state_next = (w_cnt_new != '0) ? S_DIV_X : S_DONE;
            S_DIV_X: if (w_bit_last) w_state_next = S_DIV_Y;
            S_DIV_Y: if (w_bit_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = w_start ? S_ACCUM : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_x     <= '0;
            r_y     <= '0;
            r_count <= '0;
            r_xsum  <= '0;
            r_ysum  <= '0;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_bit   <= '0;
            r_qx    <= '0;
            r_x_pos <= '0;
            r_y_pos <= '0;
            r_valid <= 1'b0;
            r_found <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x     <= w_x_wrap ? '0 : w_cur_x + INPUT_WIDTH'(1);
                r_y     <= w_x_wrap ? w_cur_y + INPUT_WIDTH'(1) : w_cur_y;
                r_count <= w_cnt_new;
                r_xsum  <= w_xsum_new;
                r_ysum  <= w_ysum_new;
            end

            if ((r_state == S_ACCUM) && (w_state_next == S_DIV_X)) begin
                r_dvd <= w_xsum_new;
                r_rem <= '0;
                r_bit <= '0;
            end else if ((r_state == S_DIV_X) || (r_state == S_DIV_Y)) begin
                r_dvd <= w_quo_next;
                r_rem <= w_rem_next;
                r_bit <= r_bit + BW'(1);
                if (w_bit_last) begin
                    r_dvd <= r_ysum;
                    r_rem <= '0;
                    r_bit <= '0;
                end
            end

            if ((r_state == S_DIV_X) && w_bit_last) begin
                r_qx <= w_quo_next[INPUT_WIDTH-1:0];
            end

            // Results are registered on entry to DONE so they are visible with the pulse.
            r_valid <= (w_state_next == S_DONE);
            if ((r_state == S_DIV_Y) && w_bit_last) begin
                r_x_pos <= r_qx;
                r_y_pos <= w_quo_next[INPUT_WIDTH-1:0];
                r_found <= 1'b1;
            end else if ((r_state == S_ACCUM) && (w_state_next == S_DONE)) begin
                r_found <= 1'b0;
            end
        end
    end

    assign x_position     = r_x_pos;
    assign y_position     = r_y_pos;
    assign valid_position = r_valid;
    assign object_found   = r_found;
    assign busy           = (r_state == S_DIV_X) || (r_state == S_DIV_Y) || (r_state == S_DONE);

endmodule

// File: doc/centroid_sequencer.md
CENTROID_SEQUENCER -- requirements
Module: centroid_sequencer

Interface
REQ-001 SHALL provide parameter INPUT_WIDTH, default 11, the width of the raster coordinate counters and of the position outputs.
REQ-002 SHALL provide parameter H_ACTIVE, default 640, the number of active pixels per line.
REQ-003 SHALL provide parameter V_ACTIVE, default 480, the number of active lines per frame.
REQ-004 SHALL provide parameter SUM_WIDTH, default 27, the width of the coordinate accumulators and of the divider.
REQ-005 SHALL provide parameter COUNT_WIDTH, default 19, the width of the object-pixel counter.
REQ-006 SHALL use one clock and an asynchronous, active-low reset. The clock port is clk and the reset port is aresetn.
REQ-007 clk  input  1  sole clock; all state changes on the rising edge.
REQ-008 aresetn  input  1  asynchronous, active-low reset.
REQ-009 frame_start  input  1  pulse marking pixel (0,0) of a frame; it qualifies the same-cycle pixel_valid.
REQ-010 pixel_valid  input  1  an active pixel is present this cycle.
REQ-011 object_pixel  input  1  the current pixel belongs to the object (thresholded delta mask); ignored unless pixel_valid=1.
REQ-012 x_position  output  INPUT_WIDTH  centroid column of the last completed frame.
REQ-013 y_position  output  INPUT_WIDTH  centroid row of the last completed frame.
REQ-014 valid_position  output  1  one-cycle pulse: the result of a frame is ready.
REQ-015 object_found  output  1  the last completed frame contained at least one object pixel; updates with valid_position.
REQ-016 busy  output  1  high in the DIV_X, DIV_Y and DONE states.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCUM, DIV_X, DIV_Y and DONE.
REQ-018 IDLE: frame_start=1 and pixel_valid=1 -> ACCUM. The counters and sums clear, and that pixel is processed as (0,0).
REQ-019 ACCUM: on each pixel_valid, the x counter increments. At x=H_ACTIVE-1 the x counter wraps to 0 and the y counter increments.
REQ-020 ACCUM: for pixel_valid and object_pixel, count+=1, x_sum+=x and y_sum+=y in the same cycle.
REQ-021 ACCUM: a pixel_valid=0 cycle leaves all counters and sums unchanged.
REQ-022 ACCUM: frame_start with pixel_valid restarts the frame. The accumulators reload with that pixel only, at (0,0); the partial frame is discarded and no valid_position pulse is produced.
REQ-023 ACCUM: after accepting the pixel at (H_ACTIVE-1, V_ACTIVE-1), go to DIV_X if count>0, else to DONE.
REQ-024 DIV_X: perform a restoring unsigned division x_sum/count, one quotient bit per cycle, MSB first, in exactly SUM_WIDTH cycles. Then go to DIV_Y.
REQ-025 DIV_Y: perform the same division for y_sum/count in SUM_WIDTH cycles. Then go to DONE.
REQ-026 Quotients SHALL truncate toward zero. The low INPUT_WIDTH bits drive the outputs; the upper bits are zero by construction.
REQ-027 DONE: for one cycle, assert valid_position. Load x_position and y_position with the quotients if count>0, else hold their previous values. Load object_found with (count>0). Go to IDLE.
REQ-028 DONE with frame_start and pixel_valid in the same cycle: go to ACCUM directly, as in REQ-018, and still pulse valid_position.
REQ-029 frame_start in DIV_X or DIV_Y SHALL be ignored and that frame dropped; the division is never aborted.
REQ-030 Latency: the last pixel is accepted in cycle T. With count>0, valid_position is high at T+2*SUM_WIDTH+1 (T+55 by default). With count=0, valid_position is high at T+1.
REQ-031 Outputs SHALL change only in DONE or on reset.
REQ-032 Accumulator widths SHALL hold a full frame without overflow: count up to H_ACTIVE*V_ACTIVE, and sums up to 98,150,400 at the default parameters.

Reset
REQ-033 On aresetn=0, in any state including mid-division: go to IDLE, clear all counters, sums and divider registers, and drive x_position=0, y_position=0, valid_position=0, object_found=0, busy=0.
REQ-034 After release, the block SHALL wait for a new frame_start; no stale result is ever emitted.

Verification
REQ-035 Single object pixel at (100,50) -> at T+55: valid_position=1, x_position=100, y_position=50, object_found=1.
REQ-036 Object pixels at (10,20), (11,20), (10,21), (11,21) -> x=42/4=10 and y=82/4=20 (truncation checked).
REQ-037 Full frame, every pixel an object pixel -> x=319, y=239; no overflow.
REQ-038 Empty frame after REQ-035 -> at T+1: valid_position=1, object_found=0, positions held at 100/50.
REQ-039 frame_start pulsed in DIV_Y -> ignored and the result is unchanged. A frame_start in the DONE cycle -> accepted, and the next frame's result is correct.
REQ-040 aresetn low during DIV_X -> all outputs 0 immediately and no valid_position pulse; the next full frame produces a correct result.
